switch_loader: RTL and testbench

Front-panel program loader for the DE2 lab processor, carrying data from the board into the design rather than out to the displays. The operator sets a 16-bit word on the switches and presses a key to write it to successive instruction-memory addresses. The raw active-low key is synchronised and debounced, and each write uses a request/acknowledge handshake to the memory. The block exposes its state and current address so the top level can route them to the HEX displays.

---
 rtl/loader_pkg.sv | 24 ++
 rtl/switch_loader_if.sv | 35 +++
 rtl/key_debounce.sv | 54 +++++
 rtl/switch_loader.sv | 100 ++++++++++
 tb/tb_switch_loader.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loader_pkg
// Brief    : Shared state encoding and default widths for the switch loader.
// Revision : 1.0 - initial release
// ============================================================================
package loader_pkg;

    // The encoding values are shown directly on the HEX display.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int c_addr_w    = 8;
    localparam int c_data_w    = 16;
    localparam int c_debounce  = 16;
    localparam int c_last_addr = 255;

endpackage
`default_nettype wire

// File: rtl/switch_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : switch_loader_if
// Brief    : Panel inputs and memory write handshake of the switch loader.
// Revision : 1.0 - initial release
// ============================================================================
interface switch_loader_if
    import loader_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
);
    logic              Enable;
    logic              KeyN;
    logic [DATA_W-1:0] SwData;
    logic              WrAck;
    logic              WrReq;
    logic [ADDR_W-1:0] WrAddr;
    logic [DATA_W-1:0] WrData;
    logic              Done;
    logic [2:0]        StateO;

    // master: the loader, which issues write requests
    modport master (
        input  Enable, KeyN, SwData, WrAck,
        output WrReq, WrAddr, WrData, Done, StateO
    );

    // slave: the board and memory side
    modport slave (
        output Enable, KeyN, SwData, WrAck,
        input  WrReq, WrAddr, WrData, Done, StateO
    );
endinterface
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : Synchronises and debounces an active-low key; pulses on press.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce
    import loader_pkg::*;
#(
    parameter int DEBOUNCE = c_debounce
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_key_n,
    output logic      o_key_s,
    output logic      o_press
);
    localparam int                 c_cnt_w    = $clog2(DEBOUNCE + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_key_s;
    logic               r_press;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_key_s <= 1'b1;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_key_s) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                // DEBOUNCE consecutive differing cycles: accept the new level
                r_key_s <= r_sync2;
                r_cnt   <= '0;
                r_press <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign o_key_s = r_key_s;
    assign o_press = r_press;
endmodule
`default_nettype wire

// File: rtl/switch_loader.sv
`default_nettype none
// ============================================================================
// Module   : switch_loader
// Brief    : Writes switch words to successive memory addresses on key press.
// Revision : 1.0 - initial release
// ============================================================================
module switch_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = c_addr_w,
    parameter int DATA_W    = c_data_w,
    parameter int DEBOUNCE  = c_debounce,
    parameter int LAST_ADDR = c_last_addr
) (
    input  wire logic        Clk,
    input  wire logic        Reset,
    switch_loader_if.master  bus
);
    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(LAST_ADDR);

    logic              w_key_s;
    logic              w_press;
    state_t            r_state;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_done;

    key_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_key_debounce (
        .clk     (Clk),
        .rst     (Reset),
        .i_key_n (bus.KeyN),
        .o_key_s (w_key_s),
        .o_press (w_press)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.Enable) begin
                        r_state <= ST_ARMED;
                        r_addr  <= '0;
                    end
                end
                ST_ARMED: begin
                    if (!bus.Enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_press) begin
                        r_data  <= bus.SwData;
                        r_req   <= 1'b1;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // Enable is deliberately ignored: a started write always completes
                    if (bus.WrAck) begin
                        r_req <= 1'b0;
                        if (r_addr == c_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_state <= ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!bus.Enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_key_s) begin
                        r_state <= ST_ARMED;
                    end
                end
                ST_DONE: begin
                    if (!bus.Enable) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.WrReq  = r_req;
    assign bus.WrAddr = r_addr;
    assign bus.WrData = r_data;
    assign bus.Done   = r_done;
    assign bus.StateO = r_state;
endmodule
`default_nettype wire

// File: tb/tb_switch_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_loader
// Brief    : Self-checking bench for switch_loader against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_loader;
    import loader_pkg::*;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 16;
    localparam int DEBOUNCE  = 4;
    localparam int LAST_ADDR = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    switch_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    switch_loader #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEBOUNCE  (DEBOUNCE),
        .LAST_ADDR (LAST_ADDR)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // memory responder controls
    int ack_dly   = 0;
    bit ack_tied  = 1'b0;
    bit ack_block = 1'b0;
    int req_age   = 0;

    // monitor results
    int          rises    = 0;
    int          req_len  = 0;
    int          last_len = 0;
    bit          req_prev = 1'b0;
    logic [23:0] wr_q[$];

    // reference model: enabled, next address, done
    bit m_en   = 1'b0;
    int m_addr = 0;
    bit m_done = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Acks a request ack_dly cycles after it is first seen, or always when tied.
    initial begin
        bus.WrAck = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ack_tied) begin
                bus.WrAck = 1'b1;
            end else if (bus.WrReq && !bus.WrAck && !ack_block) begin
                if (req_age >= ack_dly) bus.WrAck = 1'b1;
                else req_age++;
            end else begin
                bus.WrAck = 1'b0;
                req_age   = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.WrReq && !req_prev) rises++;
            if (bus.WrReq) begin
                req_len++;
            end else if (req_prev) begin
                last_len = req_len;
                req_len  = 0;
            end
            if (bus.WrReq && bus.WrAck) wr_q.push_back({bus.WrAddr, bus.WrData});
            req_prev = bus.WrReq;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_press(input int hold, input logic [15:0] d);
        bus.SwData = d;
        bus.KeyN   = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        bus.KeyN = 1'b1;
        repeat (30) @(posedge clk);
        #1;
    endtask

    task automatic set_enable(input bit e);
        bus.Enable = e;
        m_en       = e;
        if (e) m_addr = 0;
        else m_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int budget, output int cycles);
        cycles = 0;
        while (!bus.WrReq && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic press_and_check(input int hold, input logic [15:0] d, input int dly, input string tag);
        int          r0;
        bit          will_write;
        logic [23:0] w;
        ack_dly = dly;
        r0      = rises;
        wr_q.delete();
        will_write = (hold >= DEBOUNCE) && m_en && !m_done;
        do_press(hold, d);
        check_value({tag, "_nreq"}, 32'(rises - r0), 32'(will_write));
        check_value({tag, "_nwr"}, 32'(wr_q.size()), 32'(will_write));
        if (will_write && wr_q.size() > 0) begin
            w = wr_q.pop_front();
            check_value({tag, "_addr"}, 32'(w[23:16]), 32'(m_addr));
            check_value({tag, "_data"}, 32'(w[15:0]), 32'(d));
        end
        if (will_write) begin
            if (m_addr == LAST_ADDR) m_done = 1'b1;
            else m_addr++;
        end
        check_value({tag, "_done"}, 32'(bus.Done), 32'(m_done));
        check_value({tag, "_state"}, 32'(bus.StateO),
                    !m_en ? 32'(ST_IDLE) : (m_done ? 32'(ST_DONE) : 32'(ST_ARMED)));
        check_value({tag, "_waddr"}, 32'(bus.WrAddr), 32'(m_addr));
    endtask

    initial begin
        int          lat;
        int          cyc;
        int          r0;
        int          op;
        int          hold;
        logic [7:0]  wa;
        logic [15:0] wd;
        logic [23:0] w;

        rst        = 1'b1;
        bus.Enable = 1'b0;
        bus.KeyN   = 1'b1;
        bus.SwData = '0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_req", 32'(bus.WrReq), 32'd0);
        check_value("rst_addr", 32'(bus.WrAddr), 32'd0);
        check_value("rst_data", 32'(bus.WrData), 32'd0);
        check_value("rst_done", 32'(bus.Done), 32'd0);
        check_value("rst_state", 32'(bus.StateO), 32'(ST_IDLE));
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        set_enable(1'b1);
        check_value("arm_state", 32'(bus.StateO), 32'(ST_ARMED));

        // single write with latency measurement
        ack_dly    = 2;
        bus.SwData = 16'hA5C3;
        wr_q.delete();
        bus.KeyN = 1'b0;
        lat = 0;
        wa  = '1;
        wd  = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.WrReq && lat == 0) begin
                lat = i;
                wa  = bus.WrAddr;
                wd  = bus.WrData;
            end
        end
        check_value("sw_latency", 32'(lat), 32'd7);
        check_value("sw_addr", 32'(wa), 32'd0);
        check_value("sw_data", 32'(wd), 32'hA5C3);
        check_value("sw_post_addr", 32'(bus.WrAddr), 32'd1);
        check_value("sw_post_state", 32'(bus.StateO), 32'(ST_RELEASE));
        bus.KeyN = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_value("sw_rearm", 32'(bus.StateO), 32'(ST_ARMED));
        check_value("sw_nwr", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) begin
            w = wr_q.pop_front();
            check_value("sw_rec", 32'(w), 32'h00A5C3);
        end
        m_addr = 1;

        // bounce: five 3-cycle lows must be rejected
        r0 = rises;
        repeat (5) begin
            bus.KeyN = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            bus.KeyN = 1'b1;
            repeat (2) @(posedge clk);
            #1;
        end
        repeat (20) @(posedge clk);
        #1;
        check_value("bounce_noreq", 32'(rises - r0), 32'd0);
        press_and_check(10, 16'($urandom), $urandom_range(0, 4), "bounce_hold");

        // asynchronous reset in the middle of a write
        ack_block = 1'b1;
        bus.KeyN  = 1'b0;
        wait_req(20, cyc);
        check_value("rstw_req_seen", 32'(bus.WrReq), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_value("rstw_req", 32'(bus.WrReq), 32'd0);
        check_value("rstw_state", 32'(bus.StateO), 32'(ST_IDLE));
        check_value("rstw_addr", 32'(bus.WrAddr), 32'd0);
        bus.KeyN  = 1'b1;
        ack_block = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        m_addr = 0;
        m_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rstw_rearm", 32'(bus.StateO), 32'(ST_ARMED));
        wr_q.delete();

        // full run to LAST_ADDR, then an ignored press
        for (int k = 1; k <= 3; k++) press_and_check(6, 16'(k), $urandom_range(0, 4), "full");
        check_value("full_done", 32'(bus.Done), 32'd1);
        press_and_check(8, 16'h0004, 1, "full_extra");
        set_enable(1'b0);
        check_value("full_off_done", 32'(bus.Done), 32'd0);
        check_value("full_off_state", 32'(bus.StateO), 32'(ST_IDLE));

        // Enable falls while armed
        set_enable(1'b1);
        bus.Enable = 1'b0;
        m_en       = 1'b0;
        @(posedge clk); #1;
        check_value("abort_arm_state", 32'(bus.StateO), 32'(ST_IDLE));
        press_and_check(8, 16'($urandom), 0, "abort_arm_press");

        // Enable falls during a write with a late ack
        set_enable(1'b1);
        ack_dly    = 5;
        bus.SwData = 16'h5A5A;
        wr_q.delete();
        bus.KeyN = 1'b0;
        wait_req(20, cyc);
        check_value("abort_wr_seen", 32'(bus.WrReq), 32'd1);
        bus.Enable = 1'b0;
        m_en       = 1'b0;
        cyc = 0;
        while (bus.WrReq && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_value("abort_wr_len", 32'(cyc), 32'd6);
        check_value("abort_wr_rel", 32'(bus.StateO), 32'(ST_RELEASE));
        @(posedge clk); #1;
        check_value("abort_wr_idle", 32'(bus.StateO), 32'(ST_IDLE));
        check_value("abort_wr_nwr", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) begin
            w = wr_q.pop_front();
            check_value("abort_wr_rec", 32'(w), 32'h005A5A);
        end
        m_addr   = 1;
        bus.KeyN = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_value("abort_wr_keep", 32'(bus.WrAddr), 32'(m_addr));

        // acknowledge tied high: one-cycle requests
        set_enable(1'b1);
        ack_tied = 1'b1;
        repeat (2) begin
            press_and_check(6, 16'($urandom), 0, "tied");
            check_value("tied_len", 32'(last_len), 32'd1);
        end
        ack_tied = 1'b0;

        // randomized mix of presses, glitches and re-arming
        set_enable(1'b0);
        set_enable(1'b1);
        for (int n = 0; n < 16; n++) begin
            op = $urandom_range(0, 5);
            if (op == 0) begin
                set_enable(1'b0);
                check_value("rnd_off_state", 32'(bus.StateO), 32'(ST_IDLE));
                check_value("rnd_off_done", 32'(bus.Done), 32'd0);
                set_enable(1'b1);
            end else begin
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                   : int'($urandom_range(4, 16));
                press_and_check(hold, 16'($urandom), $urandom_range(0, 4), "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire
